// File: rtl/memory_arbiter.sv
// memory_arbiter: two-requester ownership arbiter in front of a 64-bit memory
// controller. A requester asks for ownership with i_req; while it owns the
// memory its strobes, write data and address pass combinationally to the
// controller. Releasing ownership goes through DRAIN, which waits out any
// unaligned-write sequence still in progress (i_mem_busy). Ownership is
// forcibly revoked after MAX_HOLD cycles.
//
// Ports:
//   i_clk, i_areset           clock (rising edge), async active-high reset
//   i_req[1:0]                ownership request per requester
//   o_grant[1:0]              one-hot grant (decoded from the state register)
//   i_read_64/i_write_64      per-requester 64-bit read/write strobes
//   i_write_data[127:0]       requester n write data at [64n +: 64]
//   i_addr_hi                 requester n word address at [n*ADDR_WIDTH +: ADDR_WIDTH]
//   i_addr_lo[5:0]            requester n byte offset at [3n +: 3]
//   o_rd_valid[1:0]           o_data carries read data for requester n
//   o_error/o_timeout[1:0]    sticky memory-error / forced-revoke flags
//   o_data[63:0]              read data, straight from i_mem_data
//   o_mem_*                   forwarded strobes, data and address to memory
//   i_mem_busy/i_mem_error    controller status
//   i_mem_data[63:0]          controller read data
module memory_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_HOLD   = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_areset,
  input  logic [1:0]              i_req,
  output logic [1:0]              o_grant,
  input  logic [1:0]              i_read_64,
  input  logic [1:0]              i_write_64,
  input  logic [127:0]            i_write_data,
  input  logic [2*ADDR_WIDTH-1:0] i_addr_hi,
  input  logic [5:0]              i_addr_lo,
  output logic [1:0]              o_rd_valid,
  output logic [1:0]              o_error,
  output logic [1:0]              o_timeout,
  output logic [63:0]             o_data,
  output logic                    o_mem_read_64,
  output logic                    o_mem_write_64,
  output logic [63:0]             o_mem_write_data,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr_hi,
  output logic [2:0]              o_mem_addr_lo,
  input  logic                    i_mem_busy,
  input  logic                    i_mem_error,
  input  logic [63:0]             i_mem_data
);

  localparam int unsigned CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN0  = 2'd1,
    S_OWN1  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;      // index of the most recently granted requester
  logic [1:0]       r_rd_valid;
  logic [1:0]       r_error;
  logic [1:0]       r_timeout;

  state_t           w_next;
  logic [CNT_W-1:0] w_cnt_n;
  logic             w_last_n;
  logic [1:0]       w_clr;
  logic [1:0]       w_to_set;
  logic [1:0]       w_err_set;
  logic [1:0]       w_rd_valid_n;
  logic             w_own;
  logic             w_idx;
  logic             w_owner;
  logic             w_fwd;

  // Owner decode; in DRAIN the owner is still the last-granted requester.
  always_comb begin
    w_own   = (r_state == S_OWN0) || (r_state == S_OWN1);
    w_idx   = (r_state == S_OWN1);
    w_owner = w_own ? w_idx : r_last;
    w_fwd   = w_own && i_req[w_idx];
  end

  // Memory-side forwarding: only the owner, and only while it still requests.
  always_comb begin
    o_mem_read_64    = 1'b0;
    o_mem_write_64   = 1'b0;
    o_mem_write_data = '0;
    o_mem_addr_hi    = '0;
    o_mem_addr_lo    = '0;
    if (w_fwd) begin
      o_mem_read_64    = i_read_64[w_idx];
      o_mem_write_64   = i_write_64[w_idx];
      o_mem_write_data = w_idx ? i_write_data[127:64] : i_write_data[63:0];
      o_mem_addr_hi    = w_idx ? i_addr_hi[2*ADDR_WIDTH-1:ADDR_WIDTH]
                               : i_addr_hi[ADDR_WIDTH-1:0];
      o_mem_addr_lo    = w_idx ? i_addr_lo[5:3] : i_addr_lo[2:0];
    end
  end

  // Next-state, hold counter, last-granted and flag set/clear masks.
  always_comb begin
    w_next   = r_state;
    w_cnt_n  = r_cnt;
    w_last_n = r_last;
    w_clr    = 2'b00;
    w_to_set = 2'b00;
    case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        if ((i_req == 2'b01) || ((i_req == 2'b11) && r_last)) begin
          w_next   = S_OWN0;
          w_last_n = 1'b0;
          w_clr    = 2'b01;
        end else if (i_req != 2'b00) begin
          w_next   = S_OWN1;
          w_last_n = 1'b1;
          w_clr    = 2'b10;
        end
      end
      S_OWN0, S_OWN1: begin
        if (!i_req[w_idx]) begin
          w_next = S_DRAIN;
        end else if (r_cnt == HOLD_LAST) begin
          w_next   = S_DRAIN;
          w_to_set = w_idx ? 2'b10 : 2'b01;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (!i_mem_busy) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    w_err_set    = (i_mem_error && (r_state != S_IDLE))
                   ? (w_owner ? 2'b10 : 2'b01) : 2'b00;
    w_rd_valid_n = o_mem_read_64 ? (w_idx ? 2'b10 : 2'b01) : 2'b00;
  end

  // State and flag registers; a set in the same cycle as a clear wins.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_last     <= 1'b1;
      r_rd_valid <= 2'b00;
      r_error    <= 2'b00;
      r_timeout  <= 2'b00;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_n;
      r_last     <= w_last_n;
      r_rd_valid <= w_rd_valid_n;
      r_error    <= (r_error & ~w_clr) | w_err_set;
      r_timeout  <= (r_timeout & ~w_clr) | w_to_set;
    end
  end

  assign o_grant    = {r_state == S_OWN1, r_state == S_OWN0};
  assign o_rd_valid = r_rd_valid;
  assign o_error    = r_error;
  assign o_timeout  = r_timeout;
  assign o_data     = i_mem_data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed, table-driven bench for memory_arbiter (MAX_HOLD = 4). Each record
// holds one cycle of inputs and the outputs expected during that cycle.
module tb_memory_arbiter;

  localparam logic [63:0] WD0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] WD1 = 64'hFEDC_BA98_7654_3210;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req, rd, wr;
  logic [127:0] wdata;
  logic [15:0]  addr_hi;
  logic [5:0]   addr_lo;
  logic         busy, merr;
  logic [63:0]  mdata;
  logic [1:0]   grant, rv, err, to;
  logic [63:0]  odata, mwdata;
  logic         mrd, mwr;
  logic [7:0]   maddr;
  logic [2:0]   mlo;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.ADDR_WIDTH(8), .MAX_HOLD(4)) dut (
    .i_clk(clk), .i_areset(rst), .i_req(req), .o_grant(grant),
    .i_read_64(rd), .i_write_64(wr), .i_write_data(wdata),
    .i_addr_hi(addr_hi), .i_addr_lo(addr_lo), .o_rd_valid(rv),
    .o_error(err), .o_timeout(to), .o_data(odata),
    .o_mem_read_64(mrd), .o_mem_write_64(mwr), .o_mem_write_data(mwdata),
    .o_mem_addr_hi(maddr), .o_mem_addr_lo(mlo),
    .i_mem_busy(busy), .i_mem_error(merr), .i_mem_data(mdata)
  );

  typedef struct {
    logic [1:0] req, rd, wr;
    logic [7:0] a0, a1;
    logic [2:0] lo0, lo1;
    logic       busy, err;
    logic [1:0] g, rv, er, to;
    logic       mrd, mwr;
    logic [7:0] ma;
    logic [2:0] ml;
    logic [1:0] src;   // whose write data is forwarded: 0 none, 1 req0, 2 req1
  } vec_t;

  function automatic vec_t mk(
    input logic [1:0] r, input logic [1:0] d, input logic [1:0] w,
    input logic [7:0] a0, input logic [7:0] a1,
    input logic [2:0] l0, input logic [2:0] l1,
    input logic b, input logic e,
    input logic [1:0] g, input logic [1:0] v, input logic [1:0] er,
    input logic [1:0] t, input logic mr, input logic mw,
    input logic [7:0] ma, input logic [2:0] ml, input logic [1:0] s);
    vec_t x;
    x.req = r; x.rd = d; x.wr = w; x.a0 = a0; x.a1 = a1; x.lo0 = l0; x.lo1 = l1;
    x.busy = b; x.err = e; x.g = g; x.rv = v; x.er = er; x.to = t;
    x.mrd = mr; x.mwr = mw; x.ma = ma; x.ml = ml; x.src = s;
    return x;
  endfunction

  task automatic drive(input vec_t v);
    req     = v.req;
    rd      = v.rd;
    wr      = v.wr;
    wdata   = {WD1, WD0};
    addr_hi = {v.a1, v.a0};
    addr_lo = {v.lo1, v.lo0};
    busy    = v.busy;
    merr    = v.err;
    mdata   = {32'hD00D_F00D, 32'(n_vec)};
  endtask

  task automatic check(input vec_t v, input string name);
    logic [63:0] exp_wd;
    logic [63:0] exp_od;
    exp_wd = (v.src == 2'd1) ? WD0 : (v.src == 2'd2) ? WD1 : 64'h0;
    exp_od = mdata;
    n_vec++;
    if ({grant, rv, err, to, mrd, mwr, maddr, mlo, mwdata, odata} !==
        {v.g, v.rv, v.er, v.to, v.mrd, v.mwr, v.ma, v.ml, exp_wd, exp_od}) begin
      n_bad++;
      $display("FAIL %s: got g=%b rv=%b err=%b to=%b rd=%b wr=%b a=%h lo=%h wd=%h d=%h; want g=%b rv=%b err=%b to=%b rd=%b wr=%b a=%h lo=%h wd=%h d=%h",
               name, grant, rv, err, to, mrd, mwr, maddr, mlo, mwdata, odata,
               v.g, v.rv, v.er, v.to, v.mrd, v.mwr, v.ma, v.ml, exp_wd, exp_od);
    end
  endtask

  // Apply one vector, check mid-cycle, then advance to the next falling edge.
  task automatic step(input vec_t v, input string name);
    drive(v);
    #1;
    check(v, name);
    @(negedge clk);
  endtask

  vec_t tbl[22];
  vec_t zero_v;

  initial begin
    //            req   rd    wr    a0     a1     l0 l1 bsy err  g     rv    er    to   mrd mwr ma     ml  src
    tbl[0]  = mk(2'b01,2'b01,2'b00,8'h05,8'hC3,3'd0,3'd6,1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,8'h00,3'd0,2'd0);
    tbl[1]  = mk(2'b01,2'b01,2'b00,8'h05,8'hC3,3'd0,3'd6,1'b0,1'b0, 2'b01,2'b00,2'b00,2'b00,1'b1,1'b0,8'h05,3'd0,2'd1);
    tbl[2]  = mk(2'b01,2'b10,2'b01,8'h12,8'hC3,3'd3,3'd6,1'b0,1'b0, 2'b01,2'b01,2'b00,2'b00,1'b0,1'b1,8'h12,3'd3,2'd1);
    tbl[3]  = mk(2'b11,2'b10,2'b10,8'h12,8'hC3,3'd3,3'd6,1'b0,1'b0, 2'b01,2'b00,2'b00,2'b00,1'b0,1'b0,8'h12,3'd3,2'd1);
    tbl[4]  = mk(2'b10,2'b10,2'b10,8'h12,8'hC3,3'd3,3'd6,1'b1,1'b0, 2'b01,2'b00,2'b00,2'b00,1'b0,1'b0,8'h00,3'd0,2'd0);
    tbl[5]  = mk(2'b10,2'b10,2'b10,8'h12,8'hC3,3'd3,3'd6,1'b1,1'b0, 2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,8'h00,3'd0,2'd0);
    tbl[6]  = mk(2'b10,2'b10,2'b10,8'h12,8'hC3,3'd3,3'd6,1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,8'h00,3'd0,2'd0);
    tbl[7]  = mk(2'b10,2'b00,2'b00,8'h12,8'hC3,3'd3,3'd6,1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,8'h00,3'd0,2'd0);
    tbl[8]  = mk(2'b10,2'b10,2'b01,8'h12,8'h77,3'd3,3'd5,1'b0,1'b0, 2'b10,2'b00,2'b00,2'b00,1'b1,1'b0,8'h77,3'd5,2'd2);
    tbl[9]  = mk(2'b00,2'b00,2'b00,8'h12,8'h77,3'd3,3'd5,1'b0,1'b1, 2'b10,2'b10,2'b00,2'b00,1'b0,1'b0,8'h00,3'd0,2'd0);
    tbl[10] = mk(2'b00,2'b00,2'b00,8'h12,8'h77,3'd3,3'd5,1'b0,1'b0, 2'b00,2'b00,2'b10,2'b00,1'b0,1'b0,8'h00,3'd0,2'd0);
    tbl[11] = mk(2'b11,2'b00,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b0, 2'b00,2'b00,2'b10,2'b00,1'b0,1'b0,8'h00,3'd0,2'd0);
    tbl[12] = mk(2'b11,2'b00,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b0, 2'b01,2'b00,2'b10,2'b00,1'b0,1'b0,8'h01,3'd1,2'd1);
    tbl[13] = mk(2'b11,2'b00,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b0, 2'b01,2'b00,2'b10,2'b00,1'b0,1'b0,8'h01,3'd1,2'd1);
    tbl[14] = mk(2'b11,2'b00,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b0, 2'b01,2'b00,2'b10,2'b00,1'b0,1'b0,8'h01,3'd1,2'd1);
    tbl[15] = mk(2'b11,2'b00,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b0, 2'b01,2'b00,2'b10,2'b00,1'b0,1'b0,8'h01,3'd1,2'd1);
    tbl[16] = mk(2'b11,2'b00,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b0, 2'b00,2'b00,2'b10,2'b01,1'b0,1'b0,8'h00,3'd0,2'd0);
    tbl[17] = mk(2'b11,2'b00,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b0, 2'b00,2'b00,2'b10,2'b01,1'b0,1'b0,8'h00,3'd0,2'd0);
    tbl[18] = mk(2'b01,2'b00,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b0, 2'b10,2'b00,2'b00,2'b01,1'b0,1'b0,8'h00,3'd0,2'd0);
    tbl[19] = mk(2'b01,2'b00,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b0, 2'b00,2'b00,2'b00,2'b01,1'b0,1'b0,8'h00,3'd0,2'd0);
    tbl[20] = mk(2'b01,2'b00,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b0, 2'b00,2'b00,2'b00,2'b01,1'b0,1'b0,8'h00,3'd0,2'd0);
    tbl[21] = mk(2'b01,2'b00,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b0, 2'b01,2'b00,2'b00,2'b00,1'b0,1'b0,8'h01,3'd1,2'd1);

    // Reset with all requests and strobes active: everything must stay quiet.
    rst = 1'b1;
    zero_v = mk(2'b11,2'b11,2'b11,8'h05,8'hC3,3'd0,3'd6,1'b0,1'b1,
                2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,8'h00,3'd0,2'd0);
    drive(zero_v);
    #3;
    check(zero_v, "reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Back to OWN1, read plus error pulse, then reset in the middle of the burst.
    step(mk(2'b00,2'b00,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b0,
            2'b01,2'b00,2'b00,2'b00,1'b0,1'b0,8'h00,3'd0,2'd0), "rel0");
    step(mk(2'b10,2'b00,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b0,
            2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,8'h00,3'd0,2'd0), "drain_idle");
    step(mk(2'b10,2'b00,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b0,
            2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,8'h00,3'd0,2'd0), "grant1_req");
    step(mk(2'b10,2'b10,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b1,
            2'b10,2'b00,2'b00,2'b00,1'b1,1'b0,8'hC3,3'd6,2'd2), "own1_rd_err");
    zero_v = mk(2'b10,2'b00,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b0,
                2'b10,2'b10,2'b10,2'b00,1'b0,1'b0,8'hC3,3'd6,2'd2);
    drive(zero_v);
    #1;
    check(zero_v, "err_sticky");
    rst = 1'b1;
    #1;
    check(mk(2'b10,2'b00,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b0,
             2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,8'h00,3'd0,2'd0), "mid_rst");
    @(negedge clk);
    rst = 1'b0;
    // Last-granted returns to 1 after reset, so requester 0 wins the tie.
    step(mk(2'b11,2'b00,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b0,
            2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,8'h00,3'd0,2'd0), "post_rst_idle");
    step(mk(2'b11,2'b00,2'b00,8'h01,8'hC3,3'd1,3'd6,1'b0,1'b0,
            2'b01,2'b00,2'b00,2'b00,1'b0,1'b0,8'h01,3'd1,2'd1), "post_rst_grant0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, setting the memory word-address width.
REQ-002 The block SHALL have parameter MAX_HOLD, default 1024, setting the maximum cycles one requester may hold a grant.
REQ-003 i_clk  input  1  clock; all state on rising edge.
REQ-004 i_areset  input  1  reset, asynchronous, active-high.
REQ-005 i_req  input  2  per-requester ownership request; bit n = requester n.
REQ-006 o_grant  output  2  per-requester grant; at most one bit high.
REQ-007 i_read_64  input  2  per-requester 64-bit read strobe.
REQ-008 i_write_64  input  2  per-requester 64-bit write strobe.
REQ-009 i_write_data  input  128  write data; requester n at [64n+63:64n].
REQ-010 i_addr_hi  input  2*ADDR_WIDTH  word address; requester n at [n*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 i_addr_lo  input  6  byte offset; requester n at [3n+2:3n].
REQ-012 o_rd_valid  output  2  read data on o_data valid for requester n.
REQ-013 o_error  output  2  sticky memory-error flag per requester.
REQ-014 o_timeout  output  2  sticky forced-revoke flag per requester.
REQ-015 o_data  output  64  read data, equal to i_mem_data.
REQ-016 o_mem_read_64  output  1  read strobe to memory controller.
REQ-017 o_mem_write_64  output  1  write strobe to memory controller.
REQ-018 o_mem_write_data  output  64  write data to memory controller.
REQ-019 o_mem_addr_hi  output  ADDR_WIDTH  word address to memory controller.
REQ-020 o_mem_addr_lo  output  3  byte offset to memory controller.
REQ-021 i_mem_busy  input  1  memory controller busy (unaligned-write sequence in progress).
REQ-022 i_mem_error  input  1  memory controller error indication.
REQ-023 i_mem_data  input  64  memory controller read data, valid one cycle after read strobe.

Function
REQ-024 The FSM SHALL have states IDLE, OWN0, OWN1, DRAIN; o_grant[n] SHALL be high exactly when state is OWNn.
REQ-025 In IDLE with exactly one i_req bit high, the state SHALL become OWN of that requester on the next edge.
REQ-026 In IDLE with both requests high, the grant SHALL go to the requester not most recently granted; last-granted SHALL reset to 1 so requester 0 wins first.
REQ-027 In OWNn, memory strobes, data and address SHALL be combinationally forwarded from requester n only while i_req[n] is high; otherwise all o_mem_* SHALL be 0.
REQ-028 Strobes from the non-owner SHALL be ignored and never reach the memory.
REQ-029 In OWNn, i_req[n] low SHALL move state to DRAIN on the next edge.
REQ-030 A hold counter SHALL clear on grant and increment each OWN cycle; reaching MAX_HOLD-1 SHALL force DRAIN and set o_timeout[n].
REQ-031 DRAIN SHALL last at least one cycle, forward no strobes, and return to IDLE on the first cycle i_mem_busy is low.
REQ-032 A read forwarded in cycle N SHALL assert o_rd_valid[owner] for exactly cycle N+1, even if ownership ends at N+1.
REQ-033 i_mem_error high SHALL set o_error for the current owner (during OWNn or the DRAIN following it).
REQ-034 o_error[n] and o_timeout[n] SHALL clear on the edge entering OWNn; set and clear in the same cycle SHALL set.
REQ-035 A request arriving while the other requester owns SHALL wait until DRAIN completes; no preemption except by timeout.

Reset
REQ-036 i_areset SHALL immediately force IDLE, hold counter 0, last-granted 1, and o_grant, o_rd_valid, o_error, o_timeout, o_mem_read_64, o_mem_write_64 to 0, including mid-burst.

Verification
REQ-037 i_req=01 at cycle 0 -> o_grant=01 at cycle 1; i_read_64[0]=1 addr_hi=5 lo=0 -> o_mem_addr_hi=5 same cycle, o_rd_valid=01 next cycle.
REQ-038 i_req=11 from IDLE after reset -> grant 01; requester 0 drops req -> DRAIN -> grant 10; repeat -> grant 01 (alternation).
REQ-039 Owner 0 does unaligned write then drops req, i_mem_busy high 2 cycles -> DRAIN holds 2 cycles, no grant, requester 1 strobes not forwarded.
REQ-040 MAX_HOLD=4, requester 0 holds req -> forced DRAIN after 4 OWN cycles, o_timeout=01; regrant of requester 0 clears it.
REQ-041 i_mem_error pulse while OWN1 -> o_error=10 sticky; i_areset mid-OWN1 -> all outputs 0, IDLE.
